// File: rtl/out_ser_pkg.sv
// Shared types and defaults for the output-FIFO serializer.
// Holds the FSM state encoding, default bus widths and a small decode helper.
// No logic here; imported by out_serializer and out_word_cnt.

package out_ser_pkg;

  // Default widths: one output-FIFO entry carries two host words.
  localparam int FIFO_WIDTH_DEF = 64;
  localparam int OUT_WIDTH_DEF  = 32;
  localparam int CNT_WIDTH_DEF  = 16;

  // State encoding, kept as named constants so other tools can decode a
  // captured state value without knowing the enum.
  localparam logic [2:0] ST_IDLE    = 3'b000;
  localparam logic [2:0] ST_READ    = 3'b001;
  localparam logic [2:0] ST_CAPTURE = 3'b010;
  localparam logic [2:0] ST_SEND_LO = 3'b011;
  localparam logic [2:0] ST_SEND_HI = 3'b100;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    READ    = ST_READ,
    CAPTURE = ST_CAPTURE,
    SEND_LO = ST_SEND_LO,
    SEND_HI = ST_SEND_HI
  } state_t;

  // True in the two states that present a word to the host.
  function automatic logic is_send(input state_t s);
    return (s == SEND_LO) || (s == SEND_HI);
  endfunction

endpackage

// File: rtl/out_word_cnt.sv
// Wrapping count of host words accepted by the serializer.
// Latency: count reflects a transfer one cycle after the accepting edge.
// Backpressure: none; it only observes completed transfers.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset, clears the count
//   clr  - synchronous clear, wins over a simultaneous increment
//   inc  - one accepted word this cycle
//   cnt  - current count, wraps from all-ones to zero

module out_word_cnt
  import out_ser_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      // Natural overflow of the adder gives the wrap to zero.
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/out_serializer.sv
// Drains 64-bit CIM output-FIFO entries and presents them as two 32-bit host
// words, low word first. Latency: pop strobe 1 cycle after the FIFO goes
// non-empty, first word valid 3 cycles after. Backpressure: a word is held
// stable until dout_ready; no new entry is popped while a word is unsent.
//
// Optional feature: define OUT_WCNT_EN to build the accepted-word counter;
// without it word_cnt is tied to zero.
//
// Ports:
//   clk, rst           - clock (rising edge) and async active-low reset
//   clr                - synchronous soft clear: abort, drop buffered entry
//   empty_outputfifo   - output FIFO empty flag
//   rd_en_outputfifo   - registered one-cycle pop strobe per entry
//   q_fifo             - FIFO read data, valid the cycle after the pop strobe
//   dout/dout_valid    - host word and its valid; dout is zero when not valid
//   dout_ready         - host accept; transfer = dout_valid & dout_ready
//   busy               - high whenever the FSM is not idle
//   word_cnt           - accepted-word count (zero when counter not built)

module out_serializer
  import out_ser_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  empty_outputfifo,
  output logic                  rd_en_outputfifo,
  input  logic [FIFO_WIDTH-1:0] q_fifo,
  output logic [OUT_WIDTH-1:0]  dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  state_t                state;
  state_t                state_nxt;
  logic                  rd_en_nxt;
  logic                  capture_en;
  logic                  xfer;
  logic [FIFO_WIDTH-1:0] ent_buf;

  // A transfer can only complete in a send state, so a ready pulse seen
  // while idle or fetching is simply ignored.
  assign xfer = dout_ready & is_send(state);

  // State, pop strobe and entry buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      rd_en_outputfifo <= 1'b0;
      ent_buf          <= '0;
    end else begin
      state            <= state_nxt;
      rd_en_outputfifo <= rd_en_nxt;
      if (capture_en) begin
        ent_buf <= q_fifo;
      end
    end
  end

  // Next-state, pop decision and host-side outputs.
  always_comb begin
    state_nxt  = state;
    rd_en_nxt  = 1'b0;
    capture_en = 1'b0;
    dout_valid = is_send(state);
    dout       = '0;
    busy       = (state != IDLE);

    case (state)
      IDLE: begin
        if (!empty_outputfifo) begin
          rd_en_nxt = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        // Pop strobe is registered, so it is high for this cycle only.
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        // FIFO data became valid the cycle after the pop strobe.
        capture_en = 1'b1;
        state_nxt  = SEND_LO;
      end
      SEND_LO: begin
        dout = ent_buf[OUT_WIDTH-1:0];
        if (xfer) begin
          state_nxt = SEND_HI;
        end
      end
      SEND_HI: begin
        dout = ent_buf[FIFO_WIDTH-1:OUT_WIDTH];
        if (xfer) begin
          // Back-to-back fetch keeps the 4-cycle-per-entry rhythm with no
          // idle bubble; empty is only trusted at this edge and in IDLE.
          if (!empty_outputfifo) begin
            rd_en_nxt = 1'b1;
            state_nxt = READ;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Soft clear overrides everything. The buffer keeps its old contents,
    // but it is only shown again after a fresh capture, so stale data never
    // reaches the host. A pop already issued is not undone.
    if (clr) begin
      state_nxt  = IDLE;
      rd_en_nxt  = 1'b0;
      capture_en = 1'b0;
    end
  end

`ifdef OUT_WCNT_EN
  out_word_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_word_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (xfer),
    .cnt (word_cnt)
  );
`else
  assign word_cnt = '0;
`endif

endmodule
